shared_cntr_arb: RTL and testbench
==================================

Name: shared_cntr_arb

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit up-counter between 4 requesters.
- Each requester needs a timed interval, e.g. display blink, debounce or guess-entry timeout in the game logic.
- A granted requester gets the counter, which runs from 0 to that requester's programmed limit. The block then pulses that requester's done line and releases the counter.
- It sits between the game FSMs and the shared counter datapath.

Parameters:
WIDTH, 16, counter and limit width in bits; requester count fixed at 4.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req  in  4  level request per requester; held high until done or abandoned.
lim_flat  in  4*WIDTH  terminal counts; requester i uses bits [i*WIDTH +: WIDTH], sampled only at grant.
grant  out  4  one-hot (or zero) current owner.
done  out  4  one-cycle pulse to owner when its interval completes.
busy  out  1  high while any grant is active.
cnt_q  out  WIDTH  current shared counter value.

Behaviour:
- Reset: synchronous, active-high; reset dominates every other input.
  - On a clock edge with reset=1: grant=0, done=0, busy=0, cnt_q=0, state=IDLE, rr pointer=0 (requester 0 has highest priority next).
  - Reset mid-RUN aborts the interval with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - grant=0, busy=0, cnt_q held at 0.
  - If any req bit is high, select the first set bit, searching circularly from rr pointer (ptr, ptr+1, ... mod 4).
  - Next edge: grant=onehot(sel), busy=1, lim_latched=lim_flat slice sel, cnt_q=0, rr pointer=(sel+1) mod 4, state=RUN.
  - No request: remain in IDLE.
- RUN:
  - If req[owner]=0: abort. Next edge: state=IDLE, grant=0, cnt_q=0, no done pulse. The rr pointer keeps its already-advanced value.
  - Else if cnt_q == lim_latched: next edge state=DONE, cnt_q holds.
  - Else: cnt_q <= cnt_q+1. Wrap is impossible because the terminal compare fires at or before all-ones.
- DONE:
  - done[owner]=1 for exactly this cycle; grant and busy stay high.
  - Next edge: state=IDLE, grant=0, busy=0, done=0, cnt_q=0.
  - A req drop during DONE has no effect.
- Timing for limit L with requester waiting in IDLE:
  - grant visible 1 cycle after the req sample edge.
  - RUN lasts L+1 cycles (cnt_q=0..L).
  - done pulses in the (L+2)th cycle after grant rises.
  - grant falls one cycle later.
  - At least 1 IDLE cycle separates consecutive grants.
- Limit 0: RUN lasts 1 cycle, done follows.
- Limit of all-ones: counter reaches 2^WIDTH-1, then DONE.
- lim_flat changes after grant are ignored for the current interval.
- Simultaneous requests: only one grant; the others wait. Fairness: every continuously asserted requester is granted within 4 grants.
- A requester that keeps req high after done is eligible again at the next IDLE, subject to rr order.
- Outputs grant, done, busy and cnt_q are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Single request, limit 3:
  - Stimulus: reset, then req=0001, lim0=3.
  - Required: grant=0001 one cycle after the sample edge; cnt_q 0,1,2,3; done=0001 for one cycle on the 5th cycle of grant; grant=0 the cycle after.
- Round robin: req=1111 held, all limits 1.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001.
  - Each grant is 3 cycles long with one idle cycle between grants.
  - Exactly one done pulse per grant.
- Abort:
  - Stimulus: req=0100, lim2=10; drop req[2] when cnt_q=4.
  - Required: next cycle grant=0, cnt_q=0, done never asserted; a following req=0001 is granted normally.
- Reset mid-RUN:
  - Stimulus: assert reset at cnt_q=5 during a lim=8 interval.
  - Required: next cycle all outputs 0; rr pointer=0, so a subsequent req=1001 grants 0001 first.
- Limit boundaries, WIDTH=4:
  - lim=0 -> done 2 cycles after grant.
  - lim=15 -> cnt_q reaches 15, no wrap to 0 before done.
  - lim changed during RUN -> original limit honoured.

Source files
------------

// File: rtl/shared_cntr_arb_if.sv
// rtl/shared_cntr_arb_if.sv - requester-side bundle for the shared counter arbiter
interface shared_cntr_arb_if #(
  parameter int WIDTH = 16
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] lim_flat;
  logic [3:0]         grant;
  logic [3:0]         done;
  logic               busy;
  logic [WIDTH-1:0]   cnt_q;

  modport master (
    output req, lim_flat,
    input  grant, done, busy, cnt_q
  );

  modport slave (
    input  req, lim_flat,
    output grant, done, busy, cnt_q
  );
endinterface

// File: rtl/shared_cntr_arb.sv
// rtl/shared_cntr_arb.sv - round-robin arbiter sharing one up-counter among 4 requesters
module shared_cntr_arb #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  shared_cntr_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;

  logic             found;
  logic [1:0]       sel;
  logic [1:0]       idx;
  logic [WIDTH-1:0] lim_sel;

  // Circular search starting at the round-robin pointer; first set request wins.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    lim_sel = bus.lim_flat[sel*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = 4'b0000;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (found) begin
          state_d = RUN;
          grant_d = 4'b0001 << sel;
          busy_d  = 1'b1;
          lim_d   = lim_sel;
          ptr_d   = sel + 2'd1;
          owner_d = sel;
        end
      end
      RUN: begin
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == lim_q) begin
          // done is registered, so it is raised on entry to DONE.
          state_d = DONE;
          done_d  = 4'b0001 << owner_q;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      done_q  <= 4'b0000;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      lim_q   <= '0;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.cnt_q = cnt_q;

endmodule

// File: tb/tb_shared_cntr_arb.sv
// tb/tb_shared_cntr_arb.sv - directed bench for shared_cntr_arb with WIDTH=4
module tb_shared_cntr_arb;
  localparam int WIDTH = 4;

  logic clk;
  logic reset;
  int   errs;
  int   chks;
  // {grant, done, busy, cnt_q}
  logic [12:0] obs;
  logic [12:0] exp;

  shared_cntr_arb_if #(.WIDTH(WIDTH)) bus ();

  shared_cntr_arb #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    obs = {bus.grant, bus.done, bus.busy, bus.cnt_q};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.lim_flat = '0;
    tick();
    tick();
    exp = {4'b0000, 4'b0000, 1'b0, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL reset_state: got %b exp %b", obs, exp); end
    reset = 1'b0;
    tick();
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL idle_no_req: got %b exp %b", obs, exp); end
  endtask

  task automatic test_single();
    bus.req = 4'b0001;
    bus.lim_flat = {4'd0, 4'd0, 4'd0, 4'd3};
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL single_grant: got %b exp %b", obs, exp); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp = {4'b0001, 4'b0000, 1'b1, 4'(k)};
      chks++;
      if (obs !== exp) begin errs++; $display("FAIL single_cnt%0d: got %b exp %b", k, obs, exp); end
    end
    tick();
    exp = {4'b0001, 4'b0001, 1'b1, 4'd3};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL single_done: got %b exp %b", obs, exp); end
    bus.req = 4'b0000;
    tick();
    exp = {4'b0000, 4'b0000, 1'b0, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL single_release: got %b exp %b", obs, exp); end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5];
    int dones;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    dones = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 4'b1111;
    bus.lim_flat = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int g = 0; g < 5; g++) begin
      tick();
      exp = {seq[g], 4'b0000, 1'b1, 4'd0};
      chks++;
      if (obs !== exp) begin errs++; $display("FAIL rr_grant%0d: got %b exp %b", g, obs, exp); end
      tick();
      exp = {seq[g], 4'b0000, 1'b1, 4'd1};
      chks++;
      if (obs !== exp) begin errs++; $display("FAIL rr_cnt%0d: got %b exp %b", g, obs, exp); end
      tick();
      if (bus.done != 4'b0000) dones++;
      exp = {seq[g], seq[g], 1'b1, 4'd1};
      chks++;
      if (obs !== exp) begin errs++; $display("FAIL rr_done%0d: got %b exp %b", g, obs, exp); end
      tick();
      if (g == 4) bus.req = 4'b0000;
      exp = {4'b0000, 4'b0000, 1'b0, 4'd0};
      chks++;
      if (obs !== exp) begin errs++; $display("FAIL rr_idle%0d: got %b exp %b", g, obs, exp); end
    end
    chks++;
    if (dones !== 5) begin errs++; $display("FAIL rr_done_count: got %0d exp 5", dones); end
  endtask

  task automatic test_abort();
    int saw_done;
    saw_done = 0;
    // pointer is 1 after the round robin, so requester 2 is reached directly
    bus.req = 4'b0100;
    bus.lim_flat = {4'd0, 4'd10, 4'd0, 4'd0};
    tick();
    exp = {4'b0100, 4'b0000, 1'b1, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL abort_grant: got %b exp %b", obs, exp); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (bus.done != 4'b0000) saw_done++;
    end
    exp = {4'b0100, 4'b0000, 1'b1, 4'd4};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL abort_cnt4: got %b exp %b", obs, exp); end
    bus.req = 4'b0000;
    tick();
    if (bus.done != 4'b0000) saw_done++;
    exp = {4'b0000, 4'b0000, 1'b0, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL abort_release: got %b exp %b", obs, exp); end
    tick();
    if (bus.done != 4'b0000) saw_done++;
    chks++;
    if (saw_done !== 0) begin errs++; $display("FAIL abort_no_done: got %0d pulses exp 0", saw_done); end
    bus.req = 4'b0001;
    bus.lim_flat = {4'd0, 4'd0, 4'd0, 4'd2};
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL abort_next_grant: got %b exp %b", obs, exp); end
    tick();
    tick();
    tick();
    exp = {4'b0001, 4'b0001, 1'b1, 4'd2};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL abort_next_done: got %b exp %b", obs, exp); end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_run();
    // pointer is 1 here, so requester 1 is granted
    bus.req = 4'b0010;
    bus.lim_flat = {4'd0, 4'd0, 4'd8, 4'd0};
    tick();
    exp = {4'b0010, 4'b0000, 1'b1, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL rst_run_grant: got %b exp %b", obs, exp); end
    for (int k = 1; k <= 5; k++) tick();
    exp = {4'b0010, 4'b0000, 1'b1, 4'd5};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL rst_run_cnt5: got %b exp %b", obs, exp); end
    reset = 1'b1;
    tick();
    exp = {4'b0000, 4'b0000, 1'b0, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL rst_run_clear: got %b exp %b", obs, exp); end
    reset = 1'b0;
    bus.req = 4'b1001;
    bus.lim_flat = {4'd2, 4'd0, 4'd0, 4'd2};
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL rst_run_ptr0: got %b exp %b", obs, exp); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_lim_zero();
    bus.req = 4'b0001;
    bus.lim_flat = {4'd0, 4'd0, 4'd0, 4'd0};
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL lim0_grant: got %b exp %b", obs, exp); end
    tick();
    exp = {4'b0001, 4'b0001, 1'b1, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL lim0_done: got %b exp %b", obs, exp); end
    bus.req = 4'b0000;
    tick();
    exp = {4'b0000, 4'b0000, 1'b0, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL lim0_release: got %b exp %b", obs, exp); end
  endtask

  task automatic test_lim_max();
    int bad;
    bad = 0;
    bus.req = 4'b0001;
    bus.lim_flat = {4'd0, 4'd0, 4'd0, 4'd15};
    tick();
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (obs !== {4'b0001, 4'b0000, 1'b1, 4'(k)}) bad++;
    end
    chks++;
    if (bad !== 0) begin errs++; $display("FAIL limmax_count: got %0d bad cycles exp 0 (last %b)", bad, obs); end
    tick();
    exp = {4'b0001, 4'b0001, 1'b1, 4'd15};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL limmax_done: got %b exp %b", obs, exp); end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.req = 4'b0001;
    bus.lim_flat = {4'd0, 4'd0, 4'd0, 4'd3};
    tick();
    // a limit change after grant must not shorten the interval
    bus.lim_flat = {4'd0, 4'd0, 4'd0, 4'd1};
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp = {4'b0001, 4'b0000, 1'b1, 4'(k)};
      chks++;
      if (obs !== exp) begin errs++; $display("FAIL limchg_cnt%0d: got %b exp %b", k, obs, exp); end
    end
    tick();
    exp = {4'b0001, 4'b0001, 1'b1, 4'd3};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL limchg_done: got %b exp %b", obs, exp); end
    tick();
    exp = {4'b0000, 4'b0000, 1'b0, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL b2b_idle: got %b exp %b", obs, exp); end
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 4'd0};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL b2b_regrant: got %b exp %b", obs, exp); end
    tick();
    tick();
    exp = {4'b0001, 4'b0001, 1'b1, 4'd1};
    chks++;
    if (obs !== exp) begin errs++; $display("FAIL b2b_new_lim_done: got %b exp %b", obs, exp); end
    bus.req = 4'b0000;
    tick();
  endtask

  initial begin
    errs = 0;
    chks = 0;
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.lim_flat = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_reset_mid_run();
    test_lim_zero();
    test_lim_max();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
